// File: rtl/pipeline_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_reg_pkg
//
// Shared definitions for the pipeline stage register and its storage
// sub-module.
//
// Contents:
//   stage_state_e    occupancy state of the stage (EMPTY / ONE / TWO)
//   WIDTH_MIN/MAX    legal range of the data width parameter
//   state_has_data() true when the main register holds a valid entry
//   state_is_full()  true when both main and skid registers are occupied
// -----------------------------------------------------------------------------
package pipeline_stage_reg_pkg;

  // Occupancy of the stage.
  // ST_EMPTY : nothing held, out_valid low.
  // ST_ONE   : main register holds the head entry.
  // ST_TWO   : main holds the head entry and skid holds the next one.
  //            Only reachable when the skid buffer is built in.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Legal range for the payload width.
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  // The main register is the only source of out_data, so "has data" is the
  // same thing as out_valid.
  function automatic logic state_has_data(input stage_state_e s);
    return (s != ST_EMPTY);
  endfunction

  // With the skid buffer present, the stage can only take a new beat while
  // at least one of the two slots is free. Decoding this from the state alone
  // keeps in_ready free of any combinational path from out_ready.
  function automatic logic state_is_full(input stage_state_e s);
    return (s == ST_TWO);
  endfunction

endpackage

// File: rtl/pipeline_stage_reg_en_register.sv
// -----------------------------------------------------------------------------
// en_register
//
// WIDTH-bit storage register with a load enable and an asynchronous,
// active-low reset to RESET_VAL. Used for both the main and the skid slot of
// the pipeline stage. When en is low the contents are simply not clocked in,
// so there is no feedback hold mux in front of the flops.
//
// Ports:
//   clk   in   clock, rising edge
//   rstn  in   asynchronous active-low reset, loads RESET_VAL
//   en    in   load enable: q <= d on the next rising edge
//   d     in   WIDTH-bit data to load
//   q     out  WIDTH-bit stored value
// -----------------------------------------------------------------------------
module en_register
  import pipeline_stage_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_reg
//
// One valid/ready pipeline stage. The output payload always comes straight
// from the main register, so the stage fully breaks the data path.
//
// With SKID_EN=1 the stage is a two-entry skid buffer: in_ready is decoded
// from the state register only, which also breaks the ready path. A beat that
// arrives while the head is stalled lands in the skid register and moves into
// main once the downstream takes the head.
//
// With SKID_EN=0 the stage is a single register whose in_ready passes
// out_ready through combinationally. That still sustains one beat per cycle
// but leaves a combinational ready path from downstream to upstream.
//
// flush discards everything held on the next rising edge and wins over any
// same-cycle input beat; in_ready may still read 1 during flush.
//
// Parameters:
//   WIDTH      payload width, 1..64
//   RESET_VAL  value loaded into main and skid at reset
//   SKID_EN    1 = two-entry skid buffer, 0 = single register
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   flush      in   synchronous discard of all held entries
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage accepts in_data this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a valid entry
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  payload, driven from the main register
// -----------------------------------------------------------------------------
module pipeline_stage_reg
  import pipeline_stage_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SKID_EN   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic SKID_ON = (SKID_EN != 0);

  stage_state_e     state;
  logic             in_xfer;
  logic             out_xfer;
  logic             main_load;
  logic             skid_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Handshake decode. A beat only counts when both valid and ready are high
  // on the same side of the stage.
  assign out_valid = state_has_data(state);
  assign in_ready  = SKID_ON ? !state_is_full(state)
                             : ((state == ST_EMPTY) | out_ready);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Occupancy state machine. flush has priority over everything except reset.
  // In ONE, a simultaneous push and pop keeps the stage at ONE with the new
  // beat in main. A push without a pop only moves to TWO when the skid slot
  // exists; in single-register mode in_ready in ONE equals out_ready, so that
  // case cannot arise, and the guard only keeps TWO unreachable outright.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (out_xfer && !in_xfer) begin
            state <= ST_EMPTY;
          end else if (in_xfer && !out_xfer && SKID_ON) begin
            state <= ST_TWO;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            state <= ST_ONE;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

  // Load enables for the two storage slots, following the same transitions
  // as the state machine above. Nothing loads during flush, so a beat offered
  // in the flush cycle never reaches the output. In TWO the input side is
  // ignored and main refills from skid as soon as the head is taken.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    if (!flush) begin
      case (state)
        ST_EMPTY: begin
          main_load = in_xfer;
        end
        ST_ONE: begin
          main_load = in_xfer & out_xfer;
          skid_load = in_xfer & ~out_xfer & SKID_ON;
        end
        ST_TWO: begin
          main_load = out_ready;
        end
        default: begin
          main_load = 1'b0;
          skid_load = 1'b0;
        end
      endcase
    end
  end

  // Main refills from skid when leaving TWO, otherwise from the input.
  assign main_d = (state == ST_TWO) ? skid_q : in_data;

  en_register #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rstn (rstn),
    .en   (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  assign out_data = main_q;

  // The skid slot only exists in skid-buffer mode. In single-register mode
  // skid_q is a constant that main_d never selects, because TWO is never
  // entered.
  if (SKID_ON) begin : g_skid
    en_register #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_skid (
      .clk  (clk),
      .rstn (rstn),
      .en   (skid_load),
      .d    (in_data),
      .q    (skid_q)
    );
  end else begin : g_no_skid
    assign skid_q = RESET_VAL;
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_reg
//
// Self-checking bench for pipeline_stage_reg. u_skid is the two-entry skid
// build and u_reg is the single-register build. Each instance has its own
// reference queue: an accepted input beat is pushed, a beat the downstream
// takes is popped and compared, and flush clears the queue. Occupancy-derived
// out_valid / in_ready expectations come from the queue depth.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_reg;

  localparam int W = 32;

  logic         clk;
  logic         rstn;

  // Skid-buffer instance signals
  logic         s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [W-1:0] s1_in_data, s1_out_data;

  // Single-register instance signals
  logic         s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [W-1:0] s0_in_data, s0_out_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  int acc1 = 0;
  int pop1 = 0;

  typedef struct packed {
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         flush;
    logic         exp_ov;
    logic [W-1:0] exp_od;
    logic         exp_ir;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vec [NVEC];

  pipeline_stage_reg #(.WIDTH(W), .RESET_VAL('0), .SKID_EN(1)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (s1_flush),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_out_valid),
    .out_ready (s1_out_ready),
    .out_data  (s1_out_data)
  );

  pipeline_stage_reg #(.WIDTH(W), .RESET_VAL('0), .SKID_EN(0)) u_reg (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (s0_flush),
    .in_valid  (s0_in_valid),
    .in_ready  (s0_in_ready),
    .in_data   (s0_in_data),
    .out_valid (s0_out_valid),
    .out_ready (s0_out_ready),
    .out_data  (s0_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    s1_in_valid  = iv;
    s1_in_data   = d;
    s1_out_ready = ordy;
    s1_flush     = fl;
  endtask

  task automatic applyStimulusReg(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    s0_in_valid  = iv;
    s0_in_data   = d;
    s0_out_ready = ordy;
    s0_flush     = fl;
  endtask

  // Called at the falling edge: compare outputs against the reference queues
  // and then advance the queues by the transfers the model expects to happen
  // on the coming rising edge.
  task automatic scoreboardCycle();
    int  sz;
    logic rdy, ox;
    // skid-buffer instance
    sz = q1.size();
    checkOutput("skid_out_valid", {63'd0, s1_out_valid}, {63'd0, (sz > 0)});
    if (sz > 0) checkOutput("skid_out_data", {32'd0, s1_out_data}, {32'd0, q1[0]});
    rdy = (sz < 2);
    checkOutput("skid_in_ready", {63'd0, s1_in_ready}, {63'd0, rdy});
    ox = (sz > 0) && s1_out_ready;
    if (ox) void'(q1.pop_front());
    if (s1_flush) q1.delete();
    else if (s1_in_valid && rdy) q1.push_back(s1_in_data);
    if (s1_in_valid && s1_in_ready) acc1++;
    if (s1_out_valid && s1_out_ready) pop1++;
    // single-register instance
    sz = q0.size();
    checkOutput("reg_out_valid", {63'd0, s0_out_valid}, {63'd0, (sz > 0)});
    if (sz > 0) checkOutput("reg_out_data", {32'd0, s0_out_data}, {32'd0, q0[0]});
    rdy = (sz == 0) || s0_out_ready;
    checkOutput("reg_in_ready", {63'd0, s0_in_ready}, {63'd0, rdy});
    ox = (sz > 0) && s0_out_ready;
    if (ox) void'(q0.pop_front());
    if (s0_flush) q0.delete();
    else if (s0_in_valid && rdy) q0.push_back(s0_in_data);
  endtask

  task automatic stepCycle();
    @(negedge clk);
    scoreboardCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // in_valid, in_data, out_ready, flush, exp out_valid, exp out_data, exp in_ready
    vec[0]  = '{1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1};
    vec[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b1};
    vec[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1};
    vec[3]  = '{1'b1, 32'hA,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1};
    vec[4]  = '{1'b1, 32'hB,         1'b0, 1'b0, 1'b1, 32'hA,         1'b1};
    vec[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA,         1'b0};
    vec[6]  = '{1'b1, 32'hD,         1'b1, 1'b0, 1'b1, 32'hA,         1'b0};
    vec[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hB,         1'b1};
    vec[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1};
    vec[9]  = '{1'b1, 32'h1,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1};
    vec[10] = '{1'b1, 32'h2,         1'b0, 1'b0, 1'b1, 32'h1,         1'b1};
    vec[11] = '{1'b1, 32'hC,         1'b0, 1'b1, 1'b1, 32'h1,         1'b0};
    vec[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1};
    vec[13] = '{1'b1, 32'h3,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1};
    vec[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h3,         1'b1};
    vec[15] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h3,         1'b1};
    vec[16] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h3,         1'b1};
    vec[17] = '{1'b1, 32'h4,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1};
    vec[18] = '{1'b1, 32'h5,         1'b0, 1'b1, 1'b1, 32'h4,         1'b1};
    vec[19] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1};

    // Reset state, checked before any clock edge
    rstn = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulusReg(1'b0, '0, 1'b0, 1'b0);
    #2;
    checkOutput("reset_out_valid", {63'd0, s1_out_valid}, 64'd0);
    checkOutput("reset_out_data", {32'd0, s1_out_data}, 64'd0);
    checkOutput("reset_in_ready", {63'd0, s1_in_ready}, 64'd1);
    checkOutput("reset_reg_in_ready", {63'd0, s0_in_ready}, 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: single pass, back-pressure into skid, flush cases
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vec[i].in_valid, vec[i].in_data, vec[i].out_ready, vec[i].flush);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_out_valid", i), {63'd0, s1_out_valid}, {63'd0, vec[i].exp_ov});
      if (vec[i].exp_ov)
        checkOutput($sformatf("vec%0d_out_data", i), {32'd0, s1_out_data}, {32'd0, vec[i].exp_od});
      checkOutput($sformatf("vec%0d_in_ready", i), {63'd0, s1_in_ready}, {63'd0, vec[i].exp_ir});
      scoreboardCycle();
      @(posedge clk);
      #1;
    end

    // Streaming 0..99 with out_ready held: one beat in and one out per cycle
    acc1 = 0;
    pop1 = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, i[W-1:0], 1'b1, 1'b0);
      stepCycle();
    end
    checkOutput("stream_accepted", 64'(acc1), 64'd100);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("stream_popped", 64'(pop1), 64'd100);
    checkOutput("stream_drained", 64'(q1.size()), 64'd0);

    // Fill to TWO, then assert reset between edges
    applyStimulus(1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 32'h5A5A_0002, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("two_in_ready_low", {63'd0, s1_in_ready}, 64'd0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {63'd0, s1_out_valid}, 64'd0);
    checkOutput("midreset_out_data", {32'd0, s1_out_data}, 64'd0);
    checkOutput("midreset_in_ready", {63'd0, s1_in_ready}, 64'd1);
    q1.delete();
    q0.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    stepCycle();

    // Single-register build: random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      applyStimulusReg(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
      stepCycle();
    end
    applyStimulusReg(1'b0, '0, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("reg_drained", 64'(q0.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per transfer, legal range 1..64.
REQ-002 SHALL have parameter RESET_VAL, default 0: value loaded into all data storage at reset, WIDTH bits.
REQ-003 SHALL have parameter SKID_EN, default 1: 1 = two-entry skid buffer, 0 = single-entry register with pass-through ready.
REQ-004 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1: synchronous discard of all held entries.
REQ-007 SHALL have port in_valid, input, 1: upstream presents in_data.
REQ-008 SHALL have port in_ready, output, 1: stage accepts in_data this cycle.
REQ-009 SHALL have port in_data, input, WIDTH: upstream payload.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a valid entry.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-012 SHALL have port out_data, output, WIDTH: payload; always driven from the main register, never combinationally from in_data.

Function
REQ-013 SHALL count a transfer on an edge only when valid and ready are both 1 on that side.
REQ-014 SHALL hold main and skid registers plus a state register: EMPTY, ONE, TWO (TWO reachable only when SKID_EN=1).
REQ-015 SHALL drive out_valid = (state != EMPTY).
REQ-016 SHALL, with SKID_EN=1, drive in_ready = (state != TWO), decoded from the state register only; no combinational path from out_ready.
REQ-017 SHALL, with SKID_EN=0, drive in_ready = (state == EMPTY) | out_ready.
REQ-018 SHALL transition EMPTY: input transfer -> ONE, main <= in_data; otherwise stay.
REQ-019 SHALL transition ONE: input and output transfer -> ONE, main <= in_data; output only -> EMPTY; input only -> TWO, skid <= in_data; neither -> stay, main unchanged.
REQ-020 SHALL transition TWO: out_ready=1 -> ONE, main <= skid; otherwise stay; in_data ignored.
REQ-021 SHALL give latency of 1 cycle from input transfer into EMPTY to out_valid=1 with that data.
REQ-022 SHALL sustain one transfer per cycle when out_ready is held 1, in both modes.
REQ-023 SHALL preserve order and never duplicate or drop an accepted entry, except on flush.
REQ-024 SHALL, with flush=1, go to EMPTY on the next edge at highest priority, discarding any same-cycle input transfer; in_ready may read 1 during flush, and upstream treats that beat as lost.
REQ-025 SHALL keep main and skid contents unchanged when no load occurs (load-enable gating, no hold mux on out_data).
REQ-026 SHALL keep out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-027 SHALL, while rstn=0, force state=EMPTY, main=skid=RESET_VAL, out_valid=0 asynchronously, independent of clk.
REQ-028 SHALL drive in_ready=1 during and after reset, per REQ-016/017 decoding of EMPTY.
REQ-029 SHALL accept the first transfer on the first rising edge after rstn deasserts; rstn assertion mid-transfer discards all entries.

Structure
REQ-030 SHALL place the state enumeration typedef and the EMPTY/ONE/TWO encodings in the shared core package.
REQ-031 SHALL instantiate sub-module en_register twice (main, skid): WIDTH-bit, load enable, asynchronous active-low reset to RESET_VAL.
REQ-032 SHALL elide the skid en_register and TWO logic when SKID_EN=0.

Verification (WIDTH=32, SKID_EN=1 unless stated)
REQ-033 SHALL cover: rstn=0 mid-run with state TWO -> out_valid=0, out_data=0, in_ready=1 immediately, before any edge.
REQ-034 SHALL cover: in_data=0x11111111 into EMPTY, out_ready=1 -> out_valid=1, out_data=0x11111111 next cycle, then EMPTY.
REQ-035 SHALL cover: out_ready=0, push 0xA, 0xB -> in_ready=0 after second; out_ready=1 -> outputs 0xA then 0xB, in_ready=1 after first pop.
REQ-036 SHALL cover: stream 0..99 with out_ready=1 -> 100 transfers in 100 consecutive cycles, in order.
REQ-037 SHALL cover: state TWO with flush=1 and in_valid=1, in_data=0xC -> EMPTY next cycle, 0xC never appears at output.
REQ-038 SHALL cover: SKID_EN=0, random in_valid/out_ready for 10000 cycles -> scoreboard match, in_ready == (!out_valid | out_ready) every cycle.
